// File: rtl/ctd_interval_sched_if.sv
// rtl/ctd_interval_sched_if.sv - key, config and countdown-control signals of the interval scheduler
interface ctd_interval_sched_if #(
  parameter int MIN_W   = 8,
  parameter int ROUND_W = 4
);
  logic               key_ss;
  logic               key_abort;
  logic               time_out;
  logic [MIN_W-1:0]   work_min;
  logic [MIN_W-1:0]   rest_min;
  logic [ROUND_W-1:0] rounds;
  logic               load;
  logic               cnt_en;
  logic [MIN_W-1:0]   min_init;
  logic [1:0]         phase;
  logic [ROUND_W-1:0] round_no;
  logic               paused;
  logic               done;

  modport master (
    input  key_ss, key_abort, time_out, work_min, rest_min, rounds,
    output load, cnt_en, min_init, phase, round_no, paused, done
  );

  modport slave (
    output key_ss, key_abort, time_out, work_min, rest_min, rounds,
    input  load, cnt_en, min_init, phase, round_no, paused, done
  );
endinterface

// File: rtl/ctd_interval_sched.sv
// rtl/ctd_interval_sched.sv - work/rest interval scheduler driving the countdown block
// rst_n is an asynchronous reset asserted HIGH despite its name.
module ctd_interval_sched #(
  parameter int MIN_W   = 8,
  parameter int ROUND_W = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  ctd_interval_sched_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD_W, RUN_W, LOAD_R, RUN_R, PAUSE, DONE} state_t;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_WORK = 2'd1;
  localparam logic [1:0] PH_REST = 2'd2;
  localparam logic [1:0] PH_DONE = 2'd3;

  state_t             state;
  logic               resume_rest;
  logic               guard;
  logic [MIN_W-1:0]   cfg_work;
  logic [MIN_W-1:0]   cfg_rest;
  logic [ROUND_W-1:0] cfg_rounds;
  logic               last_round;
  logic               expired;

  assign last_round = (bus.round_no >= cfg_rounds);
  // guard masks a 00:00 left over from before the load during the first RUN cycle
  assign expired    = bus.time_out && !guard;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state        <= IDLE;
      resume_rest  <= 1'b0;
      guard        <= 1'b0;
      cfg_work     <= '0;
      cfg_rest     <= '0;
      cfg_rounds   <= '0;
      bus.load     <= 1'b0;
      bus.cnt_en   <= 1'b0;
      bus.min_init <= '0;
      bus.phase    <= PH_IDLE;
      bus.round_no <= '0;
      bus.paused   <= 1'b0;
      bus.done     <= 1'b0;
    end else if (bus.key_abort) begin
      state        <= IDLE;
      guard        <= 1'b0;
      bus.load     <= 1'b0;
      bus.cnt_en   <= 1'b0;
      bus.phase    <= PH_IDLE;
      bus.round_no <= '0;
      bus.paused   <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.load <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.key_ss) begin
            cfg_work     <= bus.work_min;
            cfg_rest     <= bus.rest_min;
            cfg_rounds   <= (bus.rounds == '0) ? ROUND_W'(1) : bus.rounds;
            bus.round_no <= ROUND_W'(1);
            bus.min_init <= bus.work_min;
            bus.phase    <= PH_WORK;
            bus.load     <= 1'b1;
            state        <= LOAD_W;
          end
        end
        LOAD_W, LOAD_R: begin
          state      <= (state == LOAD_W) ? RUN_W : RUN_R;
          bus.cnt_en <= 1'b1;
          guard      <= 1'b1;
        end
        RUN_W: begin
          guard <= 1'b0;
          if (expired) begin
            bus.cnt_en <= 1'b0;
            if (last_round) begin
              state     <= DONE;
              bus.phase <= PH_DONE;
              bus.done  <= 1'b1;
            end else if (cfg_rest != '0) begin
              state        <= LOAD_R;
              bus.min_init <= cfg_rest;
              bus.phase    <= PH_REST;
              bus.load     <= 1'b1;
            end else begin
              state        <= LOAD_W;
              bus.round_no <= bus.round_no + ROUND_W'(1);
              bus.min_init <= cfg_work;
              bus.load     <= 1'b1;
            end
          end else if (bus.key_ss) begin
            state       <= PAUSE;
            resume_rest <= 1'b0;
            bus.paused  <= 1'b1;
            bus.cnt_en  <= 1'b0;
          end
        end
        RUN_R: begin
          guard <= 1'b0;
          if (expired) begin
            state        <= LOAD_W;
            bus.cnt_en   <= 1'b0;
            bus.round_no <= bus.round_no + ROUND_W'(1);
            bus.min_init <= cfg_work;
            bus.phase    <= PH_WORK;
            bus.load     <= 1'b1;
          end else if (bus.key_ss) begin
            state       <= PAUSE;
            resume_rest <= 1'b1;
            bus.paused  <= 1'b1;
            bus.cnt_en  <= 1'b0;
          end
        end
        PAUSE: begin
          if (bus.key_ss) begin
            state      <= resume_rest ? RUN_R : RUN_W;
            bus.paused <= 1'b0;
            bus.cnt_en <= 1'b1;
            guard      <= 1'b0;
          end
        end
        DONE: begin
          if (bus.key_ss) begin
            state        <= IDLE;
            bus.phase    <= PH_IDLE;
            bus.round_no <= '0;
            bus.done     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
